// File: rtl/ysyx_22041207_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041207_seq_mul
// Brief    : Radix-2 sequential shift-add multiplier, 64x64 -> 128 or 32-bit word mode.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041207_seq_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_valid,
  input  logic        flush,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  input  logic        mulw,
  input  logic [1:0]  mul_signed,
  output logic        mul_ready,
  output logic        out_valid,
  output logic [63:0] result_hi,
  output logic [63:0] result_lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] c_LAST_DWORD = 7'd63;
  localparam logic [6:0] c_LAST_WORD  = 7'd31;

  state_t r_state;
  state_t w_state_nxt;

  logic [127:0] r_mcand;
  logic [63:0]  r_mplier;
  logic [127:0] r_acc;
  logic [6:0]   r_cnt;
  logic         r_neg;
  logic         r_mulw;
  logic [63:0]  r_hi;
  logic [63:0]  r_lo;

  logic         w_a_sgn_en;
  logic         w_b_sgn_en;
  logic [63:0]  w_a_ext;
  logic [63:0]  w_b_ext;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [63:0]  w_a_mag;
  logic [63:0]  w_b_mag;
  logic         w_accept;
  logic         w_last;
  logic         w_load_res;
  logic [127:0] w_acc_add;
  logic [127:0] w_prod;
  logic [63:0]  w_res_hi;
  logic [63:0]  w_res_lo;

  // 2'b01 is folded into unsigned: B is only signed when A is too.
  assign w_a_sgn_en = mul_signed[1];
  assign w_b_sgn_en = mul_signed[1] & mul_signed[0];

  // Word mode sign/zero-extends bit 31 so one magnitude path serves both widths.
  assign w_a_ext = mulw ? {{32{w_a_sgn_en & multiplicand[31]}}, multiplicand[31:0]} : multiplicand;
  assign w_b_ext = mulw ? {{32{w_b_sgn_en & multiplier[31]}}, multiplier[31:0]} : multiplier;
  assign w_a_neg = w_a_sgn_en & w_a_ext[63];
  assign w_b_neg = w_b_sgn_en & w_b_ext[63];
  assign w_a_mag = w_a_neg ? (~w_a_ext + 64'd1) : w_a_ext;
  assign w_b_mag = w_b_neg ? (~w_b_ext + 64'd1) : w_b_ext;

  assign w_accept   = (r_state == S_IDLE) && mul_valid && !flush;
  assign w_last     = (r_cnt == (r_mulw ? c_LAST_WORD : c_LAST_DWORD));
  assign w_load_res = (r_state == S_CALC) && w_last && !flush;

  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod    = r_neg ? (~w_acc_add + 128'd1) : w_acc_add;
  assign w_res_lo  = r_mulw ? {{32{w_prod[31]}}, w_prod[31:0]} : w_prod[63:0];
  assign w_res_hi  = r_mulw ? 64'd0 : w_prod[127:64];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (mul_valid && !flush) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcand  <= 128'd0;
      r_mplier <= 64'd0;
      r_acc    <= 128'd0;
      r_cnt    <= 7'd0;
      r_neg    <= 1'b0;
      r_mulw   <= 1'b0;
      r_hi     <= 64'd0;
      r_lo     <= 64'd0;
    end else begin
      if (w_accept) begin
        r_mcand  <= {64'd0, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= 128'd0;
        r_cnt    <= 7'd0;
        r_neg    <= w_a_neg ^ w_b_neg;
        r_mulw   <= mulw;
      end else if ((r_state == S_CALC) && !flush) begin
        r_acc    <= w_acc_add;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 7'd1;
      end
      // Results only move on a completed, unflushed operation.
      if (w_load_res) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign mul_ready = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result_hi = r_hi;
  assign result_lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041207_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041207_seq_mul
// Brief    : Directed self-checking bench for the sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041207_seq_mul;

  logic        clk;
  logic        rst;
  logic        mul_valid;
  logic        flush;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic        mul_ready;
  logic        out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  int n_vec;
  int n_err;

  ysyx_22041207_seq_mul dut (
    .clk          (clk),
    .rst          (rst),
    .mul_valid    (mul_valid),
    .flush        (flush),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .mulw         (mulw),
    .mul_signed   (mul_signed),
    .mul_ready    (mul_ready),
    .out_valid    (out_valid),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request; noise keeps mul_valid asserted with other operands early in CALC.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic w, input logic [1:0] s, input int n,
                       input logic [63:0] ehi, input logic [63:0] elo, input bit noise);
    int lat;
    check({tag, ":ready"}, {63'd0, mul_ready}, 64'd1);
    multiplicand = a;
    multiplier   = b;
    mulw         = w;
    mul_signed   = s;
    mul_valid    = 1'b1;
    @(posedge clk); #1;
    multiplicand = ~a;
    multiplier   = ~b;
    mulw         = ~w;
    mul_signed   = ~s;
    mul_valid    = noise;
    check({tag, ":busy"}, {63'd0, mul_ready}, 64'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= 10) mul_valid = 1'b0;
    end
    mul_valid = 1'b0;
    check({tag, ":latency"}, 64'(lat), 64'(n));
    check({tag, ":hi"}, result_hi, ehi);
    check({tag, ":lo"}, result_lo, elo);
    @(posedge clk); #1;
    check({tag, ":pulse_end"}, {63'd0, out_valid}, 64'd0);
    check({tag, ":ready_after"}, {63'd0, mul_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b0;
    mul_valid    = 1'b0;
    flush        = 1'b0;
    multiplicand = 64'd0;
    multiplier   = 64'd0;
    mulw         = 1'b0;
    mul_signed   = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check("reset:out_valid", {63'd0, out_valid}, 64'd0);
    check("reset:hi", result_hi, 64'd0);
    check("reset:lo", result_lo, 64'd0);
    check("reset:ready", {63'd0, mul_ready}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op("u3x5", 64'd3, 64'd5, 1'b0, 2'b00, 64, 64'd0, 64'd15, 1'b1);
    do_op("s_m1xm1", '1, '1, 1'b0, 2'b11, 64, 64'd0, 64'd1, 1'b0);
    do_op("su_m1x2", '1, 64'd2, 1'b0, 2'b10, 64,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // Results hold while idle.
    repeat (5) @(posedge clk);
    #1;
    check("hold:hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
    check("hold:lo", result_lo, 64'hFFFF_FFFF_FFFF_FFFE);

    do_op("w_u", 64'hDEAD_BEEF_4000_0000, 64'h1234_5678_0000_0002, 1'b1, 2'b00, 32,
          64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1);
    do_op("s_min_x_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2'b11, 64,
          64'h4000_0000_0000_0000, 64'd0, 1'b0);
    do_op("s_min_x_1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 2'b11, 64,
          64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
    do_op("sig01_m1x2", '1, 64'd2, 1'b0, 2'b01, 64, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    do_op("w_s_m3x7", 64'h0000_0000_FFFF_FFFD, 64'd7, 1'b1, 2'b11, 32,
          64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);

    // Flush in IDLE blocks acceptance.
    multiplicand = 64'd9;
    multiplier   = 64'd9;
    mulw         = 1'b0;
    mul_signed   = 2'b00;
    mul_valid    = 1'b1;
    flush        = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    flush     = 1'b0;
    check("idle_flush:ready", {63'd0, mul_ready}, 64'd1);

    // Flush on the 10th CALC cycle.
    multiplicand = 64'hAAAA;
    multiplier   = 64'd3;
    mul_valid    = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush:busy", {63'd0, mul_ready}, 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush:ready", {63'd0, mul_ready}, 64'd1);
    check("flush:out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush:no_pulse", 64'(seen), 64'd0);
    check("flush:hi_kept", result_hi, 64'd0);
    check("flush:lo_kept", result_lo, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("u7x6", 64'd7, 64'd6, 1'b0, 2'b00, 64, 64'd0, 64'd42, 1'b0);

    // Reset mid-CALC, with flush and mul_valid also asserted.
    multiplicand = 64'd9;
    multiplier   = 64'd9;
    mul_valid    = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst       = 1'b0;
    flush     = 1'b1;
    mul_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst:out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst:hi", result_hi, 64'd0);
    check("midrst:lo", result_lo, 64'd0);
    check("midrst:ready", {63'd0, mul_ready}, 64'd1);
    rst       = 1'b1;
    flush     = 1'b0;
    mul_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst:still_idle", {63'd0, mul_ready}, 64'd1);
    do_op("u_ones", '1, '1, 1'b0, 2'b00, 64,
          64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
